// File: rtl/palette_lookup_arbiter_pkg.sv
// rtl/palette_lookup_arbiter_pkg.sv - shared defaults, colour struct and state type for the palette lookup arbiter
package palette_lookup_arbiter_pkg;

   localparam int DEF_NUM_REQ     = 3;
   localparam int DEF_IDX_W       = 4;
   localparam int DEF_CH_W        = 4;
   localparam int TRANSPARENT_IDX = 0;

   typedef struct packed {
      logic [DEF_CH_W-1:0] red;
      logic [DEF_CH_W-1:0] green;
      logic [DEF_CH_W-1:0] blue;
   } rgb_t;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

endpackage

// File: rtl/palette_lookup_arbiter_rom.sv
// rtl/palette_lookup_arbiter_rom.sv - combinational 16-entry palette table, index to rgb
module palette_rom
   import palette_lookup_arbiter_pkg::*;
#(
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic [IDX_W-1:0] idx,
   output rgb_t             color
);

   always_comb begin
      color = '{red: 4'h0, green: 4'h0, blue: 4'h0};
      case (idx)
         IDX_W'(0):  color = '{red: 4'h1, green: 4'h1, blue: 4'h3};
         IDX_W'(1):  color = '{red: 4'hF, green: 4'hF, blue: 4'hF};
         IDX_W'(2):  color = '{red: 4'h4, green: 4'h6, blue: 4'hE};
         IDX_W'(3):  color = '{red: 4'h0, green: 4'h0, blue: 4'h0};
         IDX_W'(4):  color = '{red: 4'hE, green: 4'h2, blue: 4'h2};
         IDX_W'(5):  color = '{red: 4'h2, green: 4'hC, blue: 4'h3};
         IDX_W'(6):  color = '{red: 4'hF, green: 4'hD, blue: 4'h2};
         IDX_W'(7):  color = '{red: 4'h8, green: 4'h4, blue: 4'h1};
         IDX_W'(8):  color = '{red: 4'h5, green: 4'h7, blue: 4'hD};
         IDX_W'(9):  color = '{red: 4'hC, green: 4'hC, blue: 4'hC};
         IDX_W'(10): color = '{red: 4'h7, green: 4'h7, blue: 4'h7};
         IDX_W'(11): color = '{red: 4'hF, green: 4'h8, blue: 4'hA};
         IDX_W'(12): color = '{red: 4'h3, green: 4'h9, blue: 4'h9};
         IDX_W'(13): color = '{red: 4'hA, green: 4'h3, blue: 4'hE};
         IDX_W'(14): color = '{red: 4'h6, green: 4'hB, blue: 4'hF};
         IDX_W'(15): color = '{red: 4'h2, green: 4'h2, blue: 4'h2};
         default:    color = '{red: 4'h0, green: 4'h0, blue: 4'h0};
      endcase
   end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// rtl/palette_lookup_arbiter.sv - round-robin arbiter sharing one palette lookup among sprite requesters
module palette_lookup_arbiter
   import palette_lookup_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int IDX_W   = DEF_IDX_W,
   parameter  int CH_W    = DEF_CH_W,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*IDX_W-1:0] req_index,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [CH_W-1:0]          red,
   output logic [CH_W-1:0]          green,
   output logic [CH_W-1:0]          blue,
   output logic                     rsp_transparent
);

   state_t             state;
   logic [ID_W-1:0]    last_granted;
   logic [ID_W-1:0]    winner;
   logic               found;
   int                 cand;
   logic [ID_W-1:0]    cand_id;
   logic [IDX_W-1:0]   sel_idx;
   logic [NUM_REQ-1:0] gnt_next;
   logic [ID_W-1:0]    s1_id;
   logic [IDX_W-1:0]   s1_idx;
   rgb_t               rom_q;

   // Search starts one past the last winner and wraps, giving round-robin fairness.
   always_comb begin
      winner  = last_granted;
      found   = 1'b0;
      cand    = 0;
      cand_id = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(last_granted) + 1 + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_id = cand[ID_W-1:0];
         if (!found && req[cand_id]) begin
            found  = 1'b1;
            winner = cand_id;
         end
      end
   end

   always_comb begin
      sel_idx  = '0;
      gnt_next = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) sel_idx = req_index[i*IDX_W +: IDX_W];
      end
      gnt_next[winner] = found;
   end

   palette_rom #(.IDX_W(IDX_W)) u_rom (
      .idx   (s1_idx),
      .color (rom_q)
   );

   // ACTIVE means a request was accepted last edge and its lookup is in flight.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state           <= ST_IDLE;
         last_granted    <= ID_W'(NUM_REQ - 1);
         gnt             <= '0;
         s1_id           <= '0;
         s1_idx          <= '0;
         rsp_valid       <= 1'b0;
         rsp_id          <= '0;
         red             <= '0;
         green           <= '0;
         blue            <= '0;
         rsp_transparent <= 1'b0;
      end else begin
         state     <= found ? ST_ACTIVE : ST_IDLE;
         gnt       <= gnt_next;
         rsp_valid <= (state == ST_ACTIVE);
         if (found) begin
            last_granted <= winner;
            s1_id        <= winner;
            s1_idx       <= sel_idx;
         end
         if (state == ST_ACTIVE) begin
            rsp_id          <= s1_id;
            red             <= CH_W'(rom_q.red);
            green           <= CH_W'(rom_q.green);
            blue            <= CH_W'(rom_q.blue);
            rsp_transparent <= (s1_idx == IDX_W'(TRANSPARENT_IDX));
         end
      end
   end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// tb/tb_palette_lookup_arbiter.sv - directed scoreboard bench for palette_lookup_arbiter
module tb_palette_lookup_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [2:0]  req = '0;
   logic [11:0] req_index = '0;
   logic [2:0]  gnt;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [3:0]  red, green, blue;
   logic        rsp_transparent;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      logic       t;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   palette_lookup_arbiter dut (
      .Clk             (Clk),
      .Reset_n         (Reset_n),
      .req             (req),
      .req_index       (req_index),
      .gnt             (gnt),
      .rsp_valid       (rsp_valid),
      .rsp_id          (rsp_id),
      .red             (red),
      .green           (green),
      .blue            (blue),
      .rsp_transparent (rsp_transparent)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] r, input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2);
      req       = r;
      req_index = {i2, i1, i0};
   endtask

   function automatic exp_t mk(input logic [1:0] id, input logic [11:0] rgb, input logic t);
      mk = '{id: id, r: rgb[11:8], g: rgb[7:4], b: rgb[3:0], t: t};
   endfunction

   // Scoreboard side: every response pulse pops the oldest expectation.
   always @(negedge Clk) begin
      if (Reset_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", exp_q.size(), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_rgb", {red, green, blue}, {e.r, e.g, e.b});
            chk("rsp_transparent", rsp_transparent, e.t);
         end
      end
   end

   initial begin
      logic [2:0] rot [6];
      rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;
      rot[3] = 3'b001; rot[4] = 3'b010; rot[5] = 3'b100;

      // reset state
      tick();
      tick();
      chk("reset_gnt", gnt, 0);
      chk("reset_valid", rsp_valid, 0);
      chk("reset_outs", {rsp_id, red, green, blue, rsp_transparent}, 0);
      Reset_n = 1'b1;

      // single request on requester 0, index 2, first edge after reset release
      drive(3'b001, 4'd2, 4'd0, 4'd0);
      exp_q.push_back(mk(2'd0, 12'h46E, 1'b0));
      tick();
      chk("single_gnt", gnt, 3'b001);
      drive(3'b000, 4'd0, 4'd0, 4'd0);
      tick();
      chk("single_valid", rsp_valid, 1);
      chk("single_gnt_clear", gnt, 0);

      // idle: no response, colour holds
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_valid", rsp_valid, 0);
         chk("idle_gnt", gnt, 0);
         chk("idle_rgb_hold", {red, green, blue}, 12'h46E);
      end

      // transparent index on requester 1
      drive(3'b010, 4'd5, 4'd0, 4'd5);
      exp_q.push_back(mk(2'd1, 12'h113, 1'b1));
      tick();
      chk("transp_gnt", gnt, 3'b010);
      drive(3'b000, 4'd0, 4'd0, 4'd0);
      tick();
      chk("transp_valid", rsp_valid, 1);
      tick();

      // grant 0, then 101 held: wrap skips idle requester 1
      drive(3'b001, 4'd8, 4'd0, 4'd0);
      exp_q.push_back(mk(2'd0, 12'h57D, 1'b0));
      tick();
      chk("wrap_gnt0", gnt, 3'b001);
      drive(3'b101, 4'd9, 4'd0, 4'd2);
      exp_q.push_back(mk(2'd2, 12'h46E, 1'b0));
      exp_q.push_back(mk(2'd0, 12'hCCC, 1'b0));
      tick();
      chk("wrap_gnt2", gnt, 3'b100);
      tick();
      chk("wrap_gnt0b", gnt, 3'b001);
      drive(3'b000, 4'd0, 4'd0, 4'd0);
      tick();
      tick();
      chk("wrap_rgb_last", {red, green, blue}, 12'hCCC);

      // reset during the grant cycle of index 3: response discarded
      drive(3'b001, 4'd3, 4'd0, 4'd0);
      tick();
      chk("flight_gnt", gnt, 3'b001);
      drive(3'b000, 4'd0, 4'd0, 4'd0);
      Reset_n = 1'b0;
      #1;
      chk("async_gnt", gnt, 0);
      chk("async_outs", {rsp_valid, rsp_id, red, green, blue, rsp_transparent}, 0);
      tick();
      chk("held_reset_valid", rsp_valid, 0);
      Reset_n = 1'b1;

      // continuous load after reset: rotation starts at requester 0
      drive(3'b111, 4'd2, 4'd8, 4'd0);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(mk(2'd0, 12'h46E, 1'b0));
         exp_q.push_back(mk(2'd1, 12'h57D, 1'b0));
         exp_q.push_back(mk(2'd2, 12'h113, 1'b1));
      end
      chk("post_reset_outs", {rsp_valid, rsp_id, red, green, blue, rsp_transparent}, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rr_gnt", gnt, rot[i]);
      end
      drive(3'b000, 4'd0, 4'd0, 4'd0);
      tick();
      chk("rr_last_valid", rsp_valid, 1);
      chk("rr_gnt_idle", gnt, 0);
      tick();
      chk("rr_drain_valid", rsp_valid, 0);
      tick();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/palette_lookup_arbiter.md
PALETTE_LOOKUP_ARBITER -- requirements
Module: palette_lookup_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of sprite requesters sharing one palette lookup.
REQ-002 Parameter IDX_W, default 4, palette index width (16 entries).
REQ-003 Parameter CH_W, default 4, width of each colour channel.
REQ-004 Clk  input  1  sole clock; all state on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester lookup request, level; held until granted.
REQ-007 req_index  input  NUM_REQ x IDX_W  palette index per requester; stable while req high.
REQ-008 gnt  output  NUM_REQ  one-hot grant, registered; asserted the cycle the request is accepted.
REQ-009 rsp_valid  output  1  response strobe, exactly one cycle per accepted request.
REQ-010 rsp_id  output  clog2(NUM_REQ)  requester number owning the response.
REQ-011 red, green, blue  output  CH_W each  looked-up colour.
REQ-012 rsp_transparent  output  1  high when the looked-up index was 0 (transparent key).

Function
REQ-013 The block SHALL accept at most one request per cycle and SHALL sustain one accept per cycle under continuous load.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod NUM_REQ, wrapping to 0.
REQ-015 gnt SHALL be a registered one-hot vector; gnt[i] high in cycle N means req_index[i] was sampled at the edge ending cycle N-1.
REQ-016 A requester SHALL drop or change req/req_index only in the cycle after its gnt is seen; a held req SHALL be re-arbitrated as a new request.
REQ-017 rsp_valid, rsp_id, colour outputs and rsp_transparent SHALL be registered and appear one cycle after the gnt cycle (2-cycle req-to-rsp latency).
REQ-018 Colour SHALL equal the palette_rom entry for the sampled index; no arithmetic on channels.
REQ-019 When no req is high, gnt SHALL be 0, the pointer SHALL hold, and rsp_valid SHALL deassert on the next cycle.
REQ-020 When all requesters request continuously, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no requester waiting more than NUM_REQ-1 cycles.
REQ-021 Colour outputs SHALL hold their last value while rsp_valid is low.
REQ-022 Internal states: IDLE (no accept last cycle) and ACTIVE (accept last cycle, response in flight); IDLE->ACTIVE on any req, ACTIVE->IDLE when no req, ACTIVE->ACTIVE on any req.

Reset
REQ-023 Asserting Reset_n low SHALL immediately clear gnt, rsp_valid, rsp_id, red, green, blue, rsp_transparent to 0 and set last_granted to NUM_REQ-1, so requester 0 has first priority.
REQ-024 A request or response in flight at reset SHALL be discarded without any rsp_valid pulse.
REQ-025 The first accept SHALL be possible in the first clock edge after Reset_n deasserts.

Structure
REQ-026 A shared package SHALL hold NUM_REQ, IDX_W and CH_W defaults, the TRANSPARENT_IDX constant (0), and the rgb_t packed struct {red, green, blue}.
REQ-027 The block SHALL contain exactly one sub-module, palette_rom: a combinational 16-entry IDX_W->rgb_t table, instantiated once.
REQ-028 palette_rom entries include idx 2 = 4'h4/4'h6/4'hE, idx 3 = 0/0/0, idx 8 = 4'h5/4'h7/4'hD, and idx 0 = 4'h1/4'h1/4'h3.
REQ-029 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-030 Reset, then req=3'b001 with index 2 for one cycle -> gnt=3'b001 next cycle; following cycle rsp_valid=1, rsp_id=0, RGB=4/6/E, rsp_transparent=0.
REQ-031 req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100; rsp_id sequence 0,1,2,0,1,2 lagging by one cycle.
REQ-032 req=3'b101 held after last grant to 0 -> next gnt 100, then 001 (wrap skips idle 1).
REQ-033 Index 0 on requester 1 -> rsp_transparent=1, RGB=1/1/3, rsp_id=1.
REQ-034 Reset_n pulsed low in the gnt cycle of index 3 -> no rsp_valid pulse; all outputs 0; next req=3'b111 granted to 0 first.
REQ-035 req idle 4 cycles after a response -> rsp_valid=0 and RGB held at last value throughout.
